// File: rtl/dac_table_8x_axis_stall_detector_if.sv
// Bundle of the monitored AXI-Stream TVALID/TREADY pairs, one bit per channel.
// The detector only observes these wires: the slave modport takes both as inputs.
interface dac_table_8x_axis_stall_detector_if #(
  parameter int NUM_CH = 3
);
  logic [NUM_CH-1:0] tvalid;
  logic [NUM_CH-1:0] tready;

  modport master (output tvalid, output tready);
  modport slave  (input  tvalid, input  tready);
endinterface

// File: rtl/dac_table_8x_axis_stall_detector.sv
// Per-stream stall detector: flags channels waiting THRESHOLD cycles for a handshake,
// and keeps sticky worst-stall and first-blocked-channel diagnostics.
module dac_table_8x_axis_stall_detector #(
  parameter  int NUM_CH    = 3,
  parameter  int CNT_W     = 16,
  parameter  int THRESHOLD = 1024,
  localparam int FC_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  dac_table_8x_axis_stall_detector_if.slave axis,
  output logic [NUM_CH-1:0]          block_sigs,
  output logic                       any_block,
  output logic [NUM_CH*CNT_W-1:0]    max_stall,
  output logic [FC_W-1:0]            first_ch,
  output logic                       first_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt     [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt [NUM_CH];
  logic [FC_W-1:0]  first_idx;

  // Waiting means exactly one side is ready: blocked producer or starved consumer.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = '0;
      if (axis.tvalid[i] ^ axis.tready[i]) begin
        cnt_nxt[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + 1'b1;
      end
    end
  end

  // Lowest blocked index, so simultaneous rises resolve to the smallest channel.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (block_sigs[i]) first_idx = FC_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      block_sigs  <= '0;
      max_stall   <= '0;
      first_ch    <= '0;
      first_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]        <= cnt_nxt[i];
        block_sigs[i] <= (cnt_nxt[i] >= THR);
      end
      if (clear) begin
        max_stall   <= '0;
        first_ch    <= '0;
        first_valid <= 1'b0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cnt_nxt[i] > max_stall[i*CNT_W +: CNT_W]) begin
            max_stall[i*CNT_W +: CNT_W] <= cnt_nxt[i];
          end
        end
        // Capture looks at registered flags, so it lands one edge after the rise.
        if (!first_valid && (|block_sigs)) begin
          first_ch    <= first_idx;
          first_valid <= 1'b1;
        end
      end
    end
  end

  assign any_block = |block_sigs;

endmodule
